// File: rtl/id_counter_param_if.sv
// Strobe/ratio inputs and recovered-clock outputs of the DPLL I/D counter.
// The master modport drives the strobes and the divide ratio; the slave modport drives the outputs.
interface id_counter_param_if #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PEND_W = 4
);
    logic                     inc;
    logic                     dec;
    logic [CNT_W-1:0]         div;
    logic                     id_out;
    logic                     wrap;
    logic signed [PEND_W-1:0] pending;
    logic                     ovf;

    modport master (
        output inc, dec, div,
        input  id_out, wrap, pending, ovf
    );

    modport slave (
        input  inc, dec, div,
        output id_out, wrap, pending, ovf
    );
endinterface

// File: rtl/id_counter_param.sv
// Increment/decrement counter for the DPLL: divides clk by a runtime ratio and applies
// at most one +/-1 clk phase step per output period from a saturating pending accumulator.
module id_counter_param #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned PEND_W = 4
) (
    input logic               clk,
    input logic               reset,
    id_counter_param_if.slave bus
);
    localparam int PendMaxInt = (2 ** (PEND_W - 1)) - 1;
    localparam int PendMinInt = -(2 ** (PEND_W - 1));
    localparam logic signed [PEND_W:0] PendMax = (PEND_W + 1)'(PendMaxInt);
    localparam logic signed [PEND_W:0] PendMin = (PEND_W + 1)'(PendMinInt);
    localparam logic signed [PEND_W:0] One     = (PEND_W + 1)'(1);
    localparam logic signed [PEND_W:0] MinusOne = '1;

    logic [CNT_W-1:0]         ph_q, ph_d;
    logic [CNT_W-1:0]         div_q, div_d;
    logic [CNT_W-1:0]         div_clamp;
    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic                     stall_q, stall_d;
    logic                     id_q, id_d;
    logic                     wrap_q, wrap_d;
    logic                     ovf_q, ovf_d;
    logic signed [PEND_W:0]   adj;
    logic signed [PEND_W:0]   delta;
    logic signed [PEND_W:0]   sum;

    assign div_clamp = (bus.div < CNT_W'(2)) ? CNT_W'(2) : bus.div;

    always_comb begin
        ph_d    = ph_q + CNT_W'(1);
        div_d   = div_q;
        stall_d = 1'b0;
        wrap_d  = 1'b0;
        adj     = '0;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        delta   = '0;

        if (ph_q == div_q - CNT_W'(1)) begin
            // After a stall the repeated last count is a plain wrap with no further correction.
            if (stall_q) begin
                ph_d   = '0;
                wrap_d = 1'b1;
            end else if (pend_q > 0) begin
                ph_d   = CNT_W'(1);
                adj    = MinusOne;
                wrap_d = 1'b1;
            end else if (pend_q < 0) begin
                ph_d    = ph_q;
                adj     = One;
                stall_d = 1'b1;
            end else begin
                ph_d   = '0;
                wrap_d = 1'b1;
            end
        end

        if (wrap_d) begin
            div_d = div_clamp;
        end

        if (bus.inc && !bus.dec) begin
            delta = One;
        end else if (bus.dec && !bus.inc) begin
            delta = MinusOne;
        end

        sum = $signed({pend_q[PEND_W-1], pend_q}) + delta + adj;
        if (sum > PendMax) begin
            pend_d = PendMax[PEND_W-1:0];
            ovf_d  = 1'b1;
        end else if (sum < PendMin) begin
            pend_d = PendMin[PEND_W-1:0];
            ovf_d  = 1'b1;
        end else begin
            pend_d = sum[PEND_W-1:0];
        end

        id_d = (ph_d < (div_d >> 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q    <= '0;
            div_q   <= div_clamp;
            pend_q  <= '0;
            stall_q <= 1'b0;
            id_q    <= 1'b1;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            id_q    <= id_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.id_out  = id_q;
    assign bus.wrap    = wrap_q;
    assign bus.pending = pend_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_id_counter_param.sv
// Bench for id_counter_param: directed strobe/ratio sequences; a monitor measures every
// output period (length and id_out high count) against a queue of expected periods.
module tb_id_counter_param;
    logic clk;
    logic reset;

    id_counter_param_if #(.CNT_W(8), .PEND_W(4)) bus ();

    id_counter_param #(.CNT_W(8), .PEND_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int per;
        int hi;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;
    int   hi    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a period runs from one wrap pulse up to the next one.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            k  = 0;
            hi = 0;
        end else if (bus.wrap) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL period unexpected wrap got=%0d/%0d", k, hi);
            end else begin
                e = q.pop_front();
                if (k != e.per || hi != e.hi) begin
                    bad++;
                    $display("FAIL period len/high got=%0d/%0d want=%0d/%0d",
                             k, hi, e.per, e.hi);
                end
            end
            k  = 1;
            hi = int'(bus.id_out);
        end else begin
            k++;
            hi += int'(bus.id_out);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        e.per = p;
        e.hi  = h;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int pend();
        return int'($signed(bus.pending));
    endfunction

    initial begin
        reset   = 1'b1;
        bus.inc = 1'b0;
        bus.dec = 1'b0;
        bus.div = 8'd8;
        tick(2);
        chk("rst id_out", int'(bus.id_out), 1);
        chk("rst wrap", int'(bus.wrap), 0);
        chk("rst pending", pend(), 0);
        chk("rst ovf", int'(bus.ovf), 0);
        reset = 1'b0;

        // Nominal div=8
        push(8, 4); push(8, 4); push(8, 4);
        tick(24);
        chk("t1 pending", pend(), 0);

        // Single inc: following period shortened to 7
        push(8, 4); push(7, 3);
        tick(3);
        bus.inc = 1'b1; tick(1); bus.inc = 1'b0;
        chk("t2 pending1", pend(), 1);
        tick(4);
        chk("t2 pending0", pend(), 0);
        tick(7);

        // Three decs: three stretched periods
        push(9, 4); push(9, 4); push(9, 4); push(8, 4);
        bus.dec = 1'b1; tick(3); bus.dec = 1'b0;
        chk("t3 pending-3", pend(), -3);
        tick(6);
        chk("t3 pending-2", pend(), -2);
        tick(9);
        chk("t3 pending-1", pend(), -1);
        tick(9);
        chk("t3 pending0", pend(), 0);
        tick(8);

        // inc&dec together; inc during the wrap cycle with pending=1
        push(8, 4); push(7, 3); push(7, 3);
        bus.inc = 1'b1; bus.dec = 1'b1; tick(1); bus.dec = 1'b0;
        chk("t4 both", pend(), 0);
        tick(1); bus.inc = 1'b0;
        chk("t4 inc", pend(), 1);
        tick(5);
        bus.inc = 1'b1; tick(1); bus.inc = 1'b0;
        chk("t4 wrap inc", pend(), 1);
        tick(7);
        chk("t4 drained", pend(), 0);
        tick(8);

        // Saturation with div=16
        bus.div = 8'd16;
        do_reset();
        push(16, 8);
        bus.inc = 1'b1; tick(9); bus.inc = 1'b0;
        chk("t5 sat pending", pend(), 7);
        chk("t5 ovf", int'(bus.ovf), 1);
        tick(7);
        chk("t5 pending6", pend(), 6);
        chk("t5 ovf sticky", int'(bus.ovf), 1);
        tick(1);
        do_reset();
        chk("t5 rst pending", pend(), 0);
        chk("t5 rst ovf", int'(bus.ovf), 0);

        // Divide-ratio changes and mid-period reset
        bus.div = 8'd8;
        do_reset();
        push(8, 4); push(5, 2); push(2, 1);
        tick(2);
        bus.div = 8'd5;
        tick(6);
        bus.div = 8'd1;
        tick(5);
        bus.div = 8'd8;
        tick(2);
        tick(4);
        do_reset();
        chk("t6 rst id_out", int'(bus.id_out), 1);
        chk("t6 rst wrap", int'(bus.wrap), 0);
        chk("t6 rst pending", pend(), 0);
        push(8, 4);
        tick(9);
        chk("queue drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
